word_frame_packer: RTL and testbench

- Serial-to-parallel frame builder.
- Accepts a stream of 10-bit words over a valid/ready handshake and packs up to 48 of them into a 480-bit frame.
- Produces the wide packed bus that downstream reduction logic (word-wise product/accumulate over b[k*10+:10]) consumes.
- Also delivers the running modulo-2^10 product of the packed words and a word count, so downstream consumers and checkers can cross-check the reduction.

---
 rtl/word_frame_packer_if.sv | 27 ++
 rtl/word_frame_packer.sv | 128 ++++++++++++
 tb/tb_word_frame_packer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/word_frame_packer_if.sv
// Handshake bundle for word_frame_packer: 10-bit word stream in, packed frame out.
// The packer uses the slave modport; the word source and frame consumer use master.
interface word_frame_packer_if #(
  parameter int WORD_W  = 10,
  parameter int N_WORDS = 48,
  parameter int CNT_W   = 6
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WORD_W-1:0]         in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [WORD_W*N_WORDS-1:0] out_data;
  logic [CNT_W-1:0]          out_count;
  logic [WORD_W-1:0]         out_prod;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_prod
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_prod
  );
endinterface

// File: rtl/word_frame_packer.sv
// Serial-to-parallel frame builder: packs up to N_WORDS words into one wide frame
// and tracks the running modulo-2^WORD_W product and word count of the frame.
module word_frame_packer #(
  parameter int WORD_W  = 10,
  parameter int N_WORDS = 48,
  parameter int CNT_W   = 6
) (
  input logic                clk,
  input logic                rst_n,
  word_frame_packer_if.slave bus
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic                      ready_r;
  logic                      valid_r;
  logic                      ready_s;
  logic                      valid_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [WORD_W*N_WORDS-1:0] data_r;
  logic [WORD_W-1:0]         prod_r;
  logic                      accept_s;
  logic                      last_word_s;
  logic                      release_s;

  // Full-width product, keeping only the low WORD_W bits.
  function automatic logic [WORD_W-1:0] mul_trunc(
    input logic [WORD_W-1:0] a,
    input logic [WORD_W-1:0] b
  );
    logic [2*WORD_W-1:0] p;
    p = {{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, b};
    return p[WORD_W-1:0];
  endfunction

  assign accept_s    = bus.in_valid && ready_r;
  assign last_word_s = (cnt_r == CNT_W'(N_WORDS - 1)) || bus.in_last;
  assign release_s   = valid_r && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FILL: begin
        if (accept_s && last_word_s) begin
          state_s = HOLD;
        end else begin
          state_s = FILL;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_s = FILL;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = FILL;
    endcase
  end

  // Handshake flags are decoded from the next state so the registered copies track the FSM.
  always_comb begin
    ready_s = 1'b0;
    valid_s = 1'b0;
    case (state_s)
      FILL:    ready_s = 1'b1;
      HOLD:    valid_s = 1'b1;
      default: begin
        ready_s = 1'b0;
        valid_s = 1'b0;
      end
    endcase
  end

  // Registered handshake flags; both low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      ready_r <= ready_s;
      valid_r <= valid_s;
    end
  end

  // Frame datapath: slot write, running product and word count; cleared on hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      data_r <= {(WORD_W*N_WORDS){1'b0}};
      prod_r <= WORD_W'(1);
    end else if (release_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      data_r <= {(WORD_W*N_WORDS){1'b0}};
      prod_r <= WORD_W'(1);
    end else if (accept_s) begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (cnt_r == CNT_W'(k)) begin
          data_r[k*WORD_W +: WORD_W] <= bus.in_data;
        end
      end
      cnt_r  <= cnt_r + CNT_W'(1);
      prod_r <= mul_trunc(prod_r, bus.in_data);
    end
  end

  assign bus.in_ready  = ready_r;
  assign bus.out_valid = valid_r;
  assign bus.out_data  = data_r;
  assign bus.out_count = cnt_r;
  assign bus.out_prod  = prod_r;

endmodule

// File: tb/tb_word_frame_packer.sv
// Randomised self-checking bench for word_frame_packer against a queue-based frame model.
module tb_word_frame_packer;
  localparam int WORD_W  = 10;
  localparam int N_WORDS = 48;
  localparam int CNT_W   = 6;
  localparam int FW      = WORD_W * N_WORDS;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  word_frame_packer_if #(.WORD_W(WORD_W), .N_WORDS(N_WORDS), .CNT_W(CNT_W)) bus ();

  word_frame_packer #(.WORD_W(WORD_W), .N_WORDS(N_WORDS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Empty-frame state seen after reset and after every hand-off.
  task automatic chk_idle(input string tag);
    chk_eq({tag, "_ready"}, bus.in_ready, 1);
    chk_eq({tag, "_valid"}, bus.out_valid, 0);
    chk_eq({tag, "_data"}, bus.out_data, 0);
    chk_eq({tag, "_count"}, bus.out_count, 0);
    chk_eq({tag, "_prod"}, bus.out_prod, 1);
  endtask

  // Offer one word (after an optional idle gap) and return just after the accepting edge.
  task automatic push_word(input logic [WORD_W-1:0] w, input logic last, input int gap);
    int budget;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.in_last  = last;
    budget = 100;
    while (!bus.in_ready && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) chk_eq("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Send a frame, check it against the model, stall the consumer, then release it.
  task automatic run_frame(input logic [WORD_W-1:0] q[$], input logic use_last,
                           input int stall, input int gap_max);
    logic [FW-1:0] exp_data;
    int            exp_prod;
    for (int i = 0; i < q.size(); i++) begin
      push_word(q[i], use_last && (i == q.size() - 1),
                (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    exp_data = '0;
    exp_prod = 1;
    for (int k = 0; k < q.size(); k++) begin
      exp_data[k*WORD_W +: WORD_W] = q[k];
      exp_prod = (exp_prod * int'(q[k])) % 1024;
    end
    chk_eq("frame_valid", bus.out_valid, 1);
    chk_eq("frame_ready", bus.in_ready, 0);
    chk_eq("frame_data", bus.out_data, exp_data);
    chk_eq("frame_count", bus.out_count, q.size());
    chk_eq("frame_prod", bus.out_prod, exp_prod);
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = WORD_W'($urandom);
      @(posedge clk);
      #1;
      chk_eq("stall_valid", bus.out_valid, 1);
      chk_eq("stall_ready", bus.in_ready, 0);
      chk_eq("stall_data", bus.out_data, exp_data);
      chk_eq("stall_count", bus.out_count, q.size());
      chk_eq("stall_prod", bus.out_prod, exp_prod);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk_idle("release");
  endtask

  initial begin
    logic [WORD_W-1:0] q[$];
    int                len;
    errors = 0;
    checks = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    chk_eq("rst_ready", bus.in_ready, 0);
    #20 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_idle("post_reset");

    q = {};
    for (int k = 0; k < N_WORDS; k++) q.push_back(WORD_W'(k));
    run_frame(q, 1'b0, 0, 0);

    q = {10'd3, 10'd7};
    run_frame(q, 1'b1, 5, 0);

    q = {};
    for (int k = 0; k < N_WORDS; k++) q.push_back(10'd2);
    run_frame(q, 1'b0, 1, 0);

    q = {10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
    run_frame(q, 1'b1, 2, 0);

    q = {10'd31, 10'd33};
    run_frame(q, 1'b1, 0, 0);

    q = {10'd32, 10'd32};
    run_frame(q, 1'b1, 0, 0);

    q = {};
    for (int k = 0; k < N_WORDS; k++) q.push_back(WORD_W'(k + 1));
    run_frame(q, 1'b1, 0, 0);

    // Reset landing between edges after 20 accepted words.
    for (int k = 0; k < 20; k++) push_word(WORD_W'(k + 100), 1'b0, 0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_eq("midrst_data", bus.out_data, 0);
    chk_eq("midrst_count", bus.out_count, 0);
    chk_eq("midrst_prod", bus.out_prod, 1);
    chk_eq("midrst_valid", bus.out_valid, 0);
    chk_eq("midrst_ready", bus.in_ready, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("after_midrst");
    q = {};
    for (int k = 0; k < N_WORDS; k++) q.push_back(WORD_W'($urandom_range(1, 1023)));
    run_frame(q, 1'b0, 0, 0);

    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, N_WORDS);
      q = {};
      for (int k = 0; k < len; k++) begin
        q.push_back(($urandom_range(0, 15) == 0) ? 10'd0 : WORD_W'($urandom_range(1, 1023)));
      end
      run_frame(q, (len < N_WORDS) ? 1'b1 : 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
